// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the 16-bit CPU.
//
// Owns the program counter and drives it to a byte-addressed instruction
// memory with asynchronous read. The big-endian 16-bit word returned for the
// current PC is captured into the IF/ID register on the next rising edge.
// The stage also handles decoder back-pressure, redirects from execute and
// a halt opcode that stops fetching until a redirect or reset.
//
// State table:
//   state  | meaning
//   S_RUN  | fetching; one word per unstalled cycle, PC advances by 2
//   S_HALT | halt opcode fetched; PC frozen, IF/ID drained after delivery
//
// Ports:
//   i_clock             sole clock, rising edge
//   i_reset             synchronous, active-high reset
//   o_pc                registered fetch address (always even, < MEM_BYTES)
//   i_instruction       memory read data for o_pc, same cycle
//   i_stall             decoder cannot accept a new IF/ID word
//   i_redirect          fetch from i_redirect_target and flush IF/ID
//   i_redirect_target   new fetch address, bit 0 ignored
//   o_ifid_instruction  latched instruction word
//   o_ifid_pc           address the latched word was fetched from
//   o_ifid_valid        IF/ID holds a live instruction
//   o_halted            fetch is stopped in S_HALT
module fetch_unit #(
    parameter int          MEM_BYTES   = 128,
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic [15:0] o_pc,
    input  logic [15:0] i_instruction,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_target,
    output logic [15:0] o_ifid_instruction,
    output logic [15:0] o_ifid_pc,
    output logic        o_ifid_valid,
    output logic        o_halted
);

    // Keeps the PC inside memory and even; upper bits are forced to zero.
    localparam logic [15:0] PC_MASK = 16'(MEM_BYTES - 1) & 16'hFFFE;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] r_ifid_instruction;
    logic [15:0] w_ifid_instruction_next;
    logic [15:0] r_ifid_pc;
    logic [15:0] w_ifid_pc_next;
    logic        r_ifid_valid;
    logic        w_ifid_valid_next;

    logic [15:0] w_pc_inc;
    logic [15:0] w_redirect_pc;
    logic        w_is_halt;

    assign w_pc_inc      = (r_pc + 16'd2) & PC_MASK;
    assign w_redirect_pc = {i_redirect_target[15:1], 1'b0} & PC_MASK;
    assign w_is_halt     = (i_instruction[15:12] == HALT_OPCODE);

    always_comb begin
        w_state_next            = r_state;
        w_pc_next               = r_pc;
        w_ifid_instruction_next = r_ifid_instruction;
        w_ifid_pc_next          = r_ifid_pc;
        w_ifid_valid_next       = r_ifid_valid;

        if (i_redirect) begin
            // Redirect beats stall and halt; the IF/ID word is squashed but
            // its data/PC fields keep their old contents.
            w_pc_next         = w_redirect_pc;
            w_ifid_valid_next = 1'b0;
            w_state_next      = S_RUN;
        end else begin
            case (r_state)
                S_HALT: begin
                    // Halt word stays visible while stalled, then drains.
                    if (!i_stall) begin
                        w_ifid_valid_next = 1'b0;
                    end
                end
                S_RUN: begin
                    if (!i_stall) begin
                        w_ifid_instruction_next = i_instruction;
                        w_ifid_pc_next          = r_pc;
                        w_ifid_valid_next       = 1'b1;
                        if (w_is_halt) begin
                            w_state_next = S_HALT;
                        end else begin
                            w_pc_next = w_pc_inc;
                        end
                    end
                end
                default: begin
                    w_state_next = S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state            <= S_RUN;
            r_pc               <= RESET_PC;
            r_ifid_instruction <= 16'h0000;
            r_ifid_pc          <= 16'h0000;
            r_ifid_valid       <= 1'b0;
        end else begin
            r_state            <= w_state_next;
            r_pc               <= w_pc_next;
            r_ifid_instruction <= w_ifid_instruction_next;
            r_ifid_pc          <= w_ifid_pc_next;
            r_ifid_valid       <= w_ifid_valid_next;
        end
    end

    assign o_pc               = r_pc;
    assign o_ifid_instruction = r_ifid_instruction;
    assign o_ifid_pc          = r_ifid_pc;
    assign o_ifid_valid       = r_ifid_valid;
    assign o_halted           = (r_state == S_HALT);

endmodule
